// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the unified-memory arbiter.
// Included by the top and by the counter sub-module.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 64;

  // Width needed to hold 0..limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Saturating up-counter with clear and a limit flag.
// STICKY=1 keeps the flag until reset (watchdog); STICKY=0 clears it with the count.
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT  = DEF_TIMEOUT,
  parameter int CW     = cnt_width(LIMIT),
  parameter bit STICKY = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          flag
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_reg;
  logic          flag_reg;
  logic          at_limit;
  logic          next_hits;

  assign at_limit  = (cnt_reg == LIM);
  // True when this increment lands on (or stays at) the limit.
  assign next_hits = at_limit || (CW'(cnt_reg + 1'b1) == LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      flag_reg <= 1'b0;
    end else begin
      if (clr)
        cnt_reg <= '0;
      else if (inc && !at_limit)
        cnt_reg <= cnt_reg + 1'b1;

      if (clr && !STICKY)
        flag_reg <= 1'b0;
      else if (inc && !clr && next_hits)
        flag_reg <= 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign flag = flag_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch (I) and memory-stage (D) accesses onto one multi-cycle memory,
// D-first with an anti-starvation override for I and a sticky hung-memory flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [AW-1:0] addr_i,
  output logic          done_i,
  output logic [DW-1:0] rdata_i,
  input  logic          req_d,
  input  logic          wr_d,
  input  logic [AW-1:0] addr_d,
  input  logic [DW-1:0] wdata_d,
  output logic          done_d,
  output logic [DW-1:0] rdata_d,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          err
);

  localparam bit STARVE_EN = (STARVE_LIMIT != 0);
  localparam int SCW       = cnt_width(STARVE_LIMIT);
  localparam int WCW       = cnt_width(TIMEOUT);

  arb_state_e    state_reg;
  logic          owner_reg;
  logic          mem_req_reg;
  logic          mem_wr_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic          done_i_reg;
  logic          done_d_reg;
  logic [DW-1:0] rdata_i_reg;
  logic [DW-1:0] rdata_d_reg;
  logic          busy_reg;

  logic           grant_i;
  logic           any_req;
  logic           starve_full;
  logic           starve_inc;
  logic           starve_clr;
  logic [SCW-1:0] starve_cnt;
  logic           wd_inc;
  logic           wd_clr;
  logic [WCW-1:0] wd_cnt;
  logic           unused_cnt;

  assign any_req = req_i || req_d;
  assign grant_i = req_i && (!req_d || (STARVE_EN && starve_full));

  // Only contested D grants count toward starving I.
  assign starve_inc = (state_reg == ARB_IDLE) && req_d && req_i && !grant_i;
  assign starve_clr = (state_reg == ARB_IDLE) && grant_i;

  assign wd_inc = (state_reg == ARB_BUSY) && !mem_ready;
  assign wd_clr = (state_reg != ARB_BUSY);

  arb_watchdog #(
    .LIMIT (STARVE_LIMIT),
    .CW    (SCW),
    .STICKY(1'b0)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (starve_clr),
    .inc (starve_inc),
    .cnt (starve_cnt),
    .flag(starve_full)
  );

  arb_watchdog #(
    .LIMIT (TIMEOUT),
    .CW    (WCW),
    .STICKY(1'b1)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .inc (wd_inc),
    .cnt (wd_cnt),
    .flag(err)
  );

  assign unused_cnt = ^{starve_cnt, wd_cnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ARB_IDLE;
      owner_reg     <= OWN_D;
      mem_req_reg   <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      done_i_reg    <= 1'b0;
      done_d_reg    <= 1'b0;
      rdata_i_reg   <= '0;
      rdata_d_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      done_i_reg <= 1'b0;
      done_d_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (any_req) begin
            owner_reg     <= grant_i ? OWN_I : OWN_D;
            mem_wr_reg    <= grant_i ? 1'b0 : wr_d;
            mem_addr_reg  <= grant_i ? addr_i : addr_d;
            mem_wdata_reg <= grant_i ? '0 : wdata_d;
            mem_req_reg   <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A late completion after a timeout still finishes the access normally.
          if (mem_ready) begin
            if (owner_reg == OWN_I) begin
              rdata_i_reg <= mem_rdata;
              done_i_reg  <= 1'b1;
            end else begin
              rdata_d_reg <= mem_rdata;
              done_d_reg  <= 1'b1;
            end
            mem_req_reg <= 1'b0;
            mem_wr_reg  <= 1'b0;
            state_reg   <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          busy_reg  <= 1'b0;
          state_reg <= ARB_IDLE;
        end
        default: begin
          mem_req_reg <= 1'b0;
          mem_wr_reg  <= 1'b0;
          busy_reg    <= 1'b0;
          state_reg   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign done_i    = done_i_reg;
  assign done_d    = done_d_reg;
  assign rdata_i   = rdata_i_reg;
  assign rdata_d   = rdata_d_reg;
  assign mem_req   = mem_req_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, contention, starvation override,
// watchdog, spurious completion and asynchronous reset mid-access.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic        done_i;
  logic [15:0] rdata_i;
  logic        req_d = 1'b0;
  logic        wr_d = 1'b0;
  logic [15:0] addr_d = '0;
  logic [15:0] wdata_d = '0;
  logic        done_d;
  logic [15:0] rdata_d;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(16), .DW(16), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .addr_i(addr_i), .done_i(done_i), .rdata_i(rdata_i),
    .req_d(req_d), .wr_d(wr_d), .addr_d(addr_d), .wdata_d(wdata_d),
    .done_d(done_d), .rdata_d(rdata_d),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err)
  );

  // Protocol monitor: exclusive done pulses and a stable memory bus while requesting.
  logic        prev_mem_req = 1'b0;
  logic [32:0] prev_bus = '0;
  always @(negedge clk) begin
    if (rst) begin
      tests_run++;
      if ((done_i && done_d) !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_exclusive: done_i=%b done_d=%b, required not both 1", done_i, done_d);
      end
      if (prev_mem_req && mem_req) begin
        tests_run++;
        if ({mem_wr, mem_addr, mem_wdata} !== prev_bus) begin
          tests_failed++;
          $display("FAIL mem_stable: bus=%h, required %h", {mem_wr, mem_addr, mem_wdata}, prev_bus);
        end
      end
    end
    prev_mem_req <= mem_req;
    prev_bus     <= {mem_wr, mem_addr, mem_wdata};
  end

  task automatic wait_mem_req(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, err, mem_req, mem_wr, done_i, done_d} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, required 000000", {busy, err, mem_req, mem_wr, done_i, done_d});
    end
    tests_run++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: got %h, required 00000000", {mem_addr, mem_wdata});
    end
    tests_run++;
    if ({rdata_i, rdata_d} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h, required 00000000", {rdata_i, rdata_d});
    end
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_single_read;
    @(negedge clk);
    req_i = 1'b1; addr_i = 16'h0040; mem_rdata = 16'hBEEF; mem_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
      tests_failed++;
      $display("FAIL single_issue: req/wr/addr=%b/%b/%h, required 1/0/0040", mem_req, mem_wr, mem_addr);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({done_i, done_d, mem_req, rdata_i} !== {1'b1, 1'b0, 1'b0, 16'hBEEF}) begin
      tests_failed++;
      $display("FAIL single_done: done_i/done_d/mem_req/rdata_i=%b/%b/%b/%h, required 1/0/0/beef",
               done_i, done_d, mem_req, rdata_i);
    end
    mem_ready = 1'b0; req_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({done_i, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_after: done_i/busy=%b/%b, required 0/0", done_i, busy);
    end
    $display("[TB] single read addr 0040 -> beef");
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    req_i = 1'b1; addr_i = 16'h0200;
    req_d = 1'b1; wr_d = 1'b1; addr_d = 16'h0100; wdata_d = 16'h1234;
    @(negedge clk);
    tests_run++;
    if ({mem_req, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0100, 16'h1234}) begin
      tests_failed++;
      $display("FAIL simul_d_first: req/wr/addr/wdata=%b/%b/%h/%h, required 1/1/0100/1234",
               mem_req, mem_wr, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({done_d, done_i} !== 2'b10) begin
      tests_failed++;
      $display("FAIL simul_done_d: done_d/done_i=%b/%b, required 1/0", done_d, done_i);
    end
    req_d = 1'b0; wr_d = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, mem_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL simul_gap: busy/mem_req=%b/%b, required 0/0", busy, mem_req);
    end
    @(negedge clk);
    tests_run++;
    if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 16'h0200}) begin
      tests_failed++;
      $display("FAIL simul_i_second: req/wr/addr=%b/%b/%h, required 1/0/0200", mem_req, mem_wr, mem_addr);
    end
    mem_rdata = 16'h5A5A; mem_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({done_i, done_d, rdata_i} !== {1'b1, 1'b0, 16'h5A5A}) begin
      tests_failed++;
      $display("FAIL simul_done_i: done_i/done_d/rdata_i=%b/%b/%h, required 1/0/5a5a", done_i, done_d, rdata_i);
    end
    req_i = 1'b0; mem_ready = 1'b0;
    $display("[TB] simultaneous: D write 0100 then I read 0200");
  endtask

  task automatic test_spurious_ready;
    @(negedge clk);
    mem_rdata = 16'hFFFF; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, mem_req, done_i, done_d, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL spurious_state: busy/mem_req/done_i/done_d/err=%b, required 00000",
               {busy, mem_req, done_i, done_d, err});
    end
    tests_run++;
    if (rdata_i !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL spurious_rdata: rdata_i=%h, required 5a5a", rdata_i);
    end
    mem_ready = 1'b0;
    $display("[TB] spurious mem_ready in idle ignored");
  endtask

  task automatic test_starvation;
    bit          ok;
    bit          exp_i;
    logic [15:0] data;
    @(negedge clk);
    req_i = 1'b1; addr_i = 16'h0300;
    req_d = 1'b1; wr_d = 1'b0; addr_d = 16'h0400;
    for (int g = 0; g < 10; g++) begin
      wait_mem_req(10, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL starve_timeout: grant %0d never issued, required mem_req within 10 cycles", g);
        break;
      end
      exp_i = (g == 4) || (g == 9);
      data  = 16'hA000 + 16'(g);
      tests_run++;
      if (mem_addr !== (exp_i ? 16'h0300 : 16'h0400)) begin
        tests_failed++;
        $display("FAIL starve_owner: grant %0d addr=%h, required %h", g, mem_addr, exp_i ? 16'h0300 : 16'h0400);
      end
      mem_rdata = data; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      tests_run++;
      if (exp_i ? ({done_i, done_d, rdata_i} !== {2'b10, data})
                : ({done_i, done_d, rdata_d} !== {2'b01, data})) begin
        tests_failed++;
        $display("FAIL starve_done: grant %0d done_i/done_d=%b/%b rdata_i=%h rdata_d=%h, required owner %s data %h",
                 g, done_i, done_d, rdata_i, rdata_d, exp_i ? "I" : "D", data);
      end
      $display("[TB] starvation grant %0d owner %s", g, exp_i ? "I" : "D");
    end
    req_i = 1'b0; req_d = 1'b0;
  endtask

  task automatic test_watchdog;
    bit ok;
    @(negedge clk);
    req_d = 1'b1; wr_d = 1'b0; addr_d = 16'h0500; mem_ready = 1'b0;
    wait_mem_req(10, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wd_issue: mem_req=%b, required 1 within 10 cycles", mem_req);
    end
    repeat (7) @(negedge clk);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_early: err=%b after 7 busy cycles, required 0", err);
    end
    @(negedge clk);
    tests_run++;
    if ({err, busy, mem_req} !== 3'b111) begin
      tests_failed++;
      $display("FAIL wd_fire: err/busy/mem_req=%b after 8 busy cycles, required 111", {err, busy, mem_req});
    end
    repeat (2) @(negedge clk);
    mem_rdata = 16'h7777; mem_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({done_d, err, rdata_d} !== {2'b11, 16'h7777}) begin
      tests_failed++;
      $display("FAIL wd_late_done: done_d/err/rdata_d=%b/%b/%h, required 1/1/7777", done_d, err, rdata_d);
    end
    mem_ready = 1'b0; req_d = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({err, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL wd_sticky: err/busy=%b/%b, required 1/0", err, busy);
    end
    $display("[TB] watchdog timeout then late completion");
  endtask

  task automatic test_async_reset;
    bit ok;
    @(negedge clk);
    req_d = 1'b1; wr_d = 1'b1; addr_d = 16'h0600; wdata_d = 16'hCAFE;
    wait_mem_req(10, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rst_issue: mem_req=%b, required 1 within 10 cycles", mem_req);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({mem_req, busy, done_d, err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_async: mem_req/busy/done_d/err=%b, required 0000", {mem_req, busy, done_d, err});
    end
    req_d = 1'b0; wr_d = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({done_i, done_d} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_no_done: done_i/done_d=%b/%b, required 0/0", done_i, done_d);
    end
    rst = 1'b1;
    @(negedge clk);
    req_i = 1'b1; addr_i = 16'h0700;
    wait_mem_req(10, ok);
    tests_run++;
    if (!ok || mem_addr !== 16'h0700 || mem_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_resume_issue: mem_req/addr/wr=%b/%h/%b, required 1/0700/0", mem_req, mem_addr, mem_wr);
    end
    mem_rdata = 16'h1357; mem_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({done_i, done_d, rdata_i} !== {2'b10, 16'h1357}) begin
      tests_failed++;
      $display("FAIL rst_resume_done: done_i/done_d/rdata_i=%b/%b/%h, required 1/0/1357", done_i, done_d, rdata_i);
    end
    mem_ready = 1'b0; req_i = 1'b0;
    @(negedge clk);
    $display("[TB] async reset mid-busy then I read 0700");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_spurious_ready();
    test_starvation();
    test_watchdog();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at 100000, required completion");
    $fatal(1, "global timeout");
  end

endmodule
